// File: rtl/mem_arbiter_pkg.sv
// Shared types for the round-robin memory arbiter.
// Defaults for bus widths, FSM state, response tag and pointer helper.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int ID_W   = 3;

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [ID_W-1:0] next_idx(
        input logic [ID_W-1:0] i,
        input int              n
    );
        return (int'(i) == n - 1) ? '0 : i + ID_W'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle of the arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int DATA_W  = mem_arb_pkg::DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W-1:0]         mem_data_out;

    modport slave (
        input  req_valid, req_we, req_lock,
        input  req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_addr, mem_we, mem_data_in
    );

    modport master (
        output req_valid, req_we, req_lock,
        output req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_addr, mem_we, mem_data_in
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Ports: req, ptr in; one-hot gnt, binary idx, any out.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]                  req,
    input  logic [mem_arb_pkg::ID_W-1:0]  ptr,
    output logic [N-1:0]                  gnt,
    output logic [mem_arb_pkg::ID_W-1:0]  idx,
    output logic                          any
);
    import mem_arb_pkg::*;

    // Outer loop walks offsets from ptr so the lowest offset wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!any && req[k] &&
                    ((int'(ptr) + i == k) ||
                     (int'(ptr) + i == k + N))) begin
                    any    = 1'b1;
                    gnt[k] = 1'b1;
                    idx    = ID_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a single-port memory with locked bursts.
// Ports: clk, rst (async active-low), bus (mem_arbiter_if.slave).
module mem_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = mem_arb_pkg::ADDR_W,
    parameter int DATA_W    = mem_arb_pkg::DATA_W,
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    localparam int BW = $clog2(MAX_BURST + 1);

    state_t             state, state_n;
    logic [ID_W-1:0]    ptr, ptr_n;
    logic [ID_W-1:0]    owner, owner_n;
    logic [BW-1:0]      beats, beats_n;
    logic [NUM_REQ-1:0] pick_gnt, own_mask, gnt;
    logic [ID_W-1:0]    pick_idx, gnt_idx;
    logic               pick_any, pick_lock;
    logic               own_valid, own_lock, rd_push;
    logic [ADDR_W-1:0]  addr_c;
    logic [DATA_W-1:0]  data_c;
    tag_t               tags [READ_LAT];
    tag_t               last;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign own_mask  = NUM_REQ'(1) << owner;
    assign own_valid = |(bus.req_valid & own_mask);
    assign own_lock  = |(bus.req_lock & own_mask);
    assign pick_lock = |(bus.req_lock & pick_gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
            beats <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            beats <= beats_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        beats_n = beats;
        unique case (state)
            ARB: begin
                if (pick_any) begin
                    ptr_n = next_idx(pick_idx, NUM_REQ);
                    // A one-beat burst limit makes lock meaningless.
                    if (MAX_BURST > 1 && pick_lock) begin
                        state_n = LOCKED;
                        owner_n = pick_idx;
                        beats_n = BW'(1);
                    end
                end
            end
            LOCKED: begin
                if (!own_lock) begin
                    state_n = ARB;
                    ptr_n   = next_idx(owner, NUM_REQ);
                    beats_n = '0;
                end else if (own_valid) begin
                    if (beats == BW'(MAX_BURST - 1)) begin
                        state_n = ARB;
                        ptr_n   = next_idx(owner, NUM_REQ);
                        beats_n = '0;
                    end else begin
                        beats_n = beats + BW'(1);
                    end
                end
            end
            default: state_n = ARB;
        endcase
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = pick_idx;
        addr_c  = '0;
        data_c  = '0;
        if (rst) begin
            if (state == ARB) begin
                gnt = pick_gnt;
            end else begin
                gnt     = own_valid ? own_mask : '0;
                gnt_idx = owner;
            end
        end
        // One-hot AND-OR mux; no grant leaves the bus at zero.
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                addr_c = bus.req_addr[k*ADDR_W +: ADDR_W];
                data_c = bus.req_wdata[k*DATA_W +: DATA_W];
            end
        end
        rd_push = |(gnt & ~bus.req_we);
    end

    assign bus.req_ready   = gnt;
    assign bus.mem_addr    = addr_c;
    assign bus.mem_data_in = data_c;
    assign bus.mem_we      = |(gnt & bus.req_we);

    // Tag shift register matching the memory read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < READ_LAT; k++) begin
                tags[k] <= '0;
            end
        end else begin
            tags[0] <= '{valid: rd_push, id: gnt_idx};
            for (int k = 1; k < READ_LAT; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign last          = tags[READ_LAT-1];
    assign bus.rsp_valid = last.valid ? (NUM_REQ'(1) << last.id) : '0;
    assign bus.rsp_rdata = bus.mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a rule-level reference model.
// Includes a behavioural single-port memory with registered read.
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int RL = 1;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .READ_LAT  (RL),
        .MAX_BURST (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory stand-in: synchronous write, registered read.
    logic [DW-1:0] mem [int];

    always @(posedge clk) begin
        logic [DW-1:0] rd;
        int a;
        a  = int'(bus.mem_addr);
        rd = mem.exists(a) ? mem[a] : '0;
        if (bus.mem_we) mem[a] = bus.mem_data_in;
        bus.mem_data_out <= bus.mem_we ? bus.mem_data_in : rd;
    end

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    int            ptr, owner, beats, cyc;
    logic [DW-1:0] shadow [int];
    rsp_t          q [$];
    int            exp_g;
    logic [N-1:0]  exp_ready, exp_rv;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din, exp_rd;
    int            n_vec, n_err;

    task automatic model_reset();
        ptr   = 0;
        owner = -1;
        beats = 0;
        q.delete();
    endtask

    task automatic set_req(input int i, input bit v, input bit we,
                           input bit lk, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[i]           = v;
        bus.req_we[i]              = we;
        bus.req_lock[i]            = lk;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, '0, '0);
    endtask

    // Predict this cycle's grant, bus drive and response.
    task automatic sample();
        @(negedge clk);
        exp_g = -1;
        if (rst) begin
            if (owner >= 0) begin
                if (bus.req_valid[owner]) exp_g = owner;
            end else begin
                for (int i = 0; i < N; i++)
                    if (exp_g < 0 && bus.req_valid[(ptr + i) % N])
                        exp_g = (ptr + i) % N;
            end
        end
        exp_ready = '0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_din   = '0;
        if (exp_g >= 0) begin
            exp_ready[exp_g] = 1'b1;
            exp_we   = bus.req_we[exp_g];
            exp_addr = bus.req_addr[exp_g*AW +: AW];
            exp_din  = bus.req_wdata[exp_g*DW +: DW];
        end
        exp_rv = '0;
        exp_rd = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv[q[0].id] = 1'b1;
            exp_rd          = q[0].data;
            q.delete(0);
        end
    endtask

    // Apply the handshake and lock rules, then cross the edge.
    task automatic advance();
        int a;
        if (rst) begin
            if (exp_g >= 0) begin
                a = int'(exp_addr);
                if (exp_we) shadow[a] = exp_din;
                else q.push_back('{cyc + RL, exp_g,
                                   shadow.exists(a) ? shadow[a] : '0});
            end
            if (owner < 0) begin
                if (exp_g >= 0) begin
                    ptr = (exp_g + 1) % N;
                    if (bus.req_lock[exp_g] && MB > 1) begin
                        owner = exp_g;
                        beats = 1;
                    end
                end
            end else if (!bus.req_lock[owner]) begin
                ptr   = (owner + 1) % N;
                owner = -1;
            end else if (exp_g >= 0) begin
                beats++;
                if (beats == MB) begin
                    ptr   = (owner + 1) % N;
                    owner = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, AW'(i + 5), '1);
        repeat (2) begin
            sample();
            n_vec++;
            if (bus.req_ready !== '0 || bus.rsp_valid !== '0) begin
                n_err++;
                $display("FAIL reset_hs: ready=%b rsp=%b want 0",
                         bus.req_ready, bus.rsp_valid);
            end
            n_vec++;
            if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0) begin
                n_err++;
                $display("FAIL reset_mem: we=%b addr=%h want 0",
                         bus.mem_we, bus.mem_addr);
            end
            advance();
        end
        rst = 1'b1;
        sample();
        n_vec++;
        if (bus.req_ready !== exp_ready || exp_ready !== 2'b01) begin
            n_err++;
            $display("FAIL reset_first_grant: got %b want 01",
                     bus.req_ready);
        end
        advance();
        idle_all();
    endtask

    task automatic test_write_read();
        idle_all();
        set_req(0, 1, 1, 0, 16'h0010, 32'h7654_3210);
        sample();
        n_vec++;
        if (bus.req_ready !== exp_ready || bus.mem_we !== 1'b1) begin
            n_err++;
            $display("FAIL wr_grant: ready=%b we=%b want %b 1",
                     bus.req_ready, bus.mem_we, exp_ready);
        end
        advance();
        set_req(0, 1, 0, 0, 16'h0010, '0);
        sample();
        advance();
        idle_all();
        sample();
        n_vec++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'h7654_3210) begin
            n_err++;
            $display("FAIL wr_rd_data: rsp=%b data=%h want 01 76543210",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        advance();
    endtask

    task automatic test_contention();
        set_req(0, 1, 0, 0, 16'h0001, '0);
        set_req(1, 1, 0, 0, 16'h0002, '0);
        for (int c = 0; c < 8; c++) begin
            sample();
            n_vec++;
            if (bus.req_ready !== exp_ready) begin
                n_err++;
                $display("FAIL cont_ready c%0d: got %b want %b",
                         c, bus.req_ready, exp_ready);
            end
            n_vec++;
            if (bus.rsp_valid !== exp_rv ||
                (exp_rv != 0 && bus.rsp_rdata !== exp_rd)) begin
                n_err++;
                $display("FAIL cont_rsp c%0d: got %b/%h want %b/%h",
                         c, bus.rsp_valid, bus.rsp_rdata, exp_rv, exp_rd);
            end
            advance();
        end
        idle_all();
    endtask

    task automatic test_locked_burst();
        int run, first_run;
        logic [N-1:0] after;
        run       = 0;
        first_run = -1;
        after     = '0;
        set_req(0, 1, 0, 0, 16'h0020, '0);
        set_req(1, 1, 0, 1, 16'h0021, '0);
        for (int c = 0; c < 12; c++) begin
            sample();
            n_vec++;
            if (bus.req_ready !== exp_ready) begin
                n_err++;
                $display("FAIL lock_ready c%0d: got %b want %b",
                         c, bus.req_ready, exp_ready);
            end
            if (bus.req_ready === 2'b10) run++;
            else if (run > 0 && first_run < 0) begin
                first_run = run;
                after     = bus.req_ready;
            end
            advance();
        end
        n_vec++;
        if (first_run != MB || after !== 2'b01) begin
            n_err++;
            $display("FAIL lock_burst: beats=%0d next=%b want %0d 01",
                     first_run, after, MB);
        end
        idle_all();
        sample();
        advance();
    endtask

    task automatic test_pipelined();
        int k;
        idle_all();
        for (int a = 0; a < 8; a++) begin
            set_req(0, 1, 1, 0, AW'(a), DW'(a));
            sample();
            advance();
        end
        k = 0;
        for (int c = 0; c < 8 + RL + 1; c++) begin
            if (c < 8) set_req(0, 1, 0, 0, AW'(c), '0);
            else idle_all();
            sample();
            n_vec++;
            if (bus.rsp_valid !== exp_ready_rsp(exp_rv)) begin
                n_err++;
                $display("FAIL pipe_valid c%0d: got %b want %b",
                         c, bus.rsp_valid, exp_rv);
            end
            if (bus.rsp_valid === 2'b01) begin
                n_vec++;
                if (bus.rsp_rdata !== DW'(k)) begin
                    n_err++;
                    $display("FAIL pipe_data %0d: got %h want %h",
                             k, bus.rsp_rdata, k);
                end
                k++;
            end
            advance();
        end
        n_vec++;
        if (k != 8) begin
            n_err++;
            $display("FAIL pipe_count: got %0d want 8", k);
        end
    endtask

    function automatic logic [N-1:0] exp_ready_rsp(input logic [N-1:0] v);
        return v;
    endfunction

    task automatic test_reset_mid_read();
        idle_all();
        set_req(0, 1, 0, 0, 16'h0003, '0);
        sample();
        advance();
        idle_all();
        rst = 1'b0;
        model_reset();
        sample();
        n_vec++;
        if (bus.rsp_valid !== exp_rv || bus.req_ready !== '0) begin
            n_err++;
            $display("FAIL midrst_rsp: rsp=%b ready=%b want 0 0",
                     bus.rsp_valid, bus.req_ready);
        end
        advance();
        rst = 1'b1;
        set_req(0, 1, 0, 0, 16'h0004, '0);
        set_req(1, 1, 0, 0, 16'h0005, '0);
        sample();
        n_vec++;
        if (bus.req_ready !== exp_ready || bus.rsp_valid !== '0) begin
            n_err++;
            $display("FAIL midrst_grant: ready=%b rsp=%b want %b 0",
                     bus.req_ready, bus.rsp_valid, exp_ready);
        end
        advance();
        idle_all();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
                        $urandom_range(0, 9) < 4,
                        AW'($urandom_range(0, 15)), DW'($urandom));
            sample();
            n_vec++;
            if (bus.req_ready !== exp_ready || bus.mem_we !== exp_we ||
                bus.mem_addr !== exp_addr || bus.mem_data_in !== exp_din) begin
                n_err++;
                $display("FAIL rnd_bus c%0d: %b %b %h %h want %b %b %h %h",
                         c, bus.req_ready, bus.mem_we, bus.mem_addr,
                         bus.mem_data_in, exp_ready, exp_we, exp_addr, exp_din);
            end
            n_vec++;
            if (bus.rsp_valid !== exp_rv ||
                (exp_rv != 0 && bus.rsp_rdata !== exp_rd)) begin
                n_err++;
                $display("FAIL rnd_rsp c%0d: got %b/%h want %b/%h",
                         c, bus.rsp_valid, bus.rsp_rdata, exp_rv, exp_rd);
            end
            advance();
        end
        idle_all();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        idle_all();
        model_reset();
        test_reset();
        test_write_read();
        test_contention();
        test_locked_burst();
        test_pipelined();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares the single-port Memory32x16 (16-bit address, 32-bit data, synchronous write, registered read) between NUM_REQ requesters. It sits directly in front of the memory, grants one valid/ready request per cycle, and drives the memory ports combinationally from the granted requester. It returns read data to the issuing requester through a latency-matched tag pipeline, and supports locked bursts bounded by a maximum beat count.

## Interface
Parameters:
- NUM_REQ, 2 — number of requesters (2..8)
- ADDR_W, 16 — memory address width
- DATA_W, 32 — memory data width
- READ_LAT, 1 — memory read latency in cycles (edge sampling address to data_out valid)
- MAX_BURST, 4 — maximum consecutive beats in a locked burst (≥1)

Ports:
- clk  in  1  — single clock, rising edge
- rst  in  1  — asynchronous, active-low reset
- req_valid  in  NUM_REQ  — request valid, one bit per requester
- req_ready  out  NUM_REQ  — request accepted this cycle (one-hot or zero)
- req_we  in  NUM_REQ  — 1 = write, 0 = read
- req_lock  in  NUM_REQ  — hold grant for the following beat
- req_addr  in  NUM_REQ*ADDR_W  — packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  — packed write data
- rsp_valid  out  NUM_REQ  — read data valid for requester i (one-hot or zero)
- rsp_rdata  out  DATA_W  — read data, shared by all requesters
- mem_addr  out  ADDR_W  — to memory addr
- mem_we  out  1  — to memory we
- mem_data_in  out  DATA_W  — to memory data_in
- mem_data_out  in  DATA_W  — from memory data_out

## Operation
- Handshake: a beat transfers at the edge where req_valid[i] && req_ready[i]. req_ready is combinational from req_valid, FSM state and priority pointer. No backpressure on responses; requesters must always accept rsp_valid.
- Memory drive: during the granted cycle, mem_addr, mem_we and mem_data_in equal the granted requester's fields. With no grant: mem_we=0, mem_addr=0, mem_data_in=0.
- FSM states:
  - ARB: grant the first valid requester at or after the pointer, searching upward modulo NUM_REQ. On a handshake the pointer becomes (grant+1) mod NUM_REQ. If req_lock of the granted requester is 1 at the handshake, go to LOCKED with owner=grant and beats=1.
  - LOCKED: only the owner can receive ready; all others stall.
    - Owner handshake: beats increments.
    - Return to ARB when the owner handshakes with req_lock=0, or beats reaches MAX_BURST, or the owner's req_lock is 0 in any cycle.
    - On return to ARB the pointer is owner+1.
- MAX_BURST=1 makes locking ineffective; the FSM never enters LOCKED.
- Tag pipeline: READ_LAT stages of {valid, id}. A read handshake pushes {1, grant}, anything else pushes {0, x}. The stage output drives rsp_valid (one-hot decode of id). rsp_rdata = mem_data_out combinationally.
- Writes complete at handshake and produce no response.
- Reset: asynchronous, active-low, valid mid-operation. In-flight tags are discarded, FSM goes to ARB, pointer=0, beats=0.
- Reset values: req_ready=0 and rsp_valid=0 while rst=0. The mem outputs take the no-grant values.

## Timing
- Accept latency 0: a request presented to an idle arbiter at the pointer position is accepted at the next edge.
- Read latency: a read accepted at edge T produces rsp_valid in the cycle after edge T+READ_LAT-1. With READ_LAT=1, that is the cycle immediately following the handshake.
- Throughput: one beat per cycle. Back-to-back reads return in order, one per cycle.
- Write followed by read to the same address on consecutive beats returns the new data (memory is write-then-read ordered).
- Arbitration decision and FSM transition take effect on the same edge as the handshake.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W and DATA_W defaults
  - state enum typedef {ARB, LOCKED}
  - tag struct typedef {valid, id}
- Sub-module rr_pick: combinational, NUM_REQ request vector + pointer -> one-hot grant + binary index.
- mem_arbiter contains the FSM, pointer, beat counter, tag pipeline and output muxing.

## Test plan
- Reset: hold rst=0 with all req_valid=1. Required: req_ready=0, rsp_valid=0, mem_we=0, mem_addr=0. After release, the first grant goes to requester 0.
- Write/read: req0 writes addr 0x0010, data 0x76543210, then reads 0x0010. Required: rsp_valid=2'b01 one cycle after the read handshake, rsp_rdata=0x76543210.
- Contention: req0 and req1 both continuously issue reads to 0x0001 and 0x0002. Required: grants alternate 0,1,0,1; rsp_valid alternates 01,10 one cycle behind.
- Locked burst: MAX_BURST=4; req1 holds lock with valid while req0 is valid. Required: req1 receives exactly 4 consecutive beats, then req0 is granted on the next cycle.
- Pipelined reads: req0 reads addresses 0..7 on consecutive cycles after a prior write of data=addr. Required: rsp_valid high for 8 consecutive cycles, rsp_rdata = 0..7 in order.
- Reset mid-read: rst driven low in the cycle after a read handshake. Required: no rsp_valid pulse. After release, the FSM is in ARB with pointer=0.
